// File: rtl/montar_pin.sv
// Keypad PIN assembler: buffers up to four digits and emits a one-cycle packet on ENTER.
// Optional inactivity timeout is compiled in with `define MONTAR_PIN_TIMEOUT_EN.
module montar_pin #(
  parameter int         TIMEOUT_CYCLES = 250_000_000,
  parameter logic [3:0] KEY_ENTER      = 4'hF,
  parameter logic [3:0] KEY_BACK       = 4'hB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [16:0] pin_out,
  output logic [2:0]  digit_count,
  output logic        timeout_pulse
);

  localparam logic [3:0] BLANK = 4'hA;

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  digit_reg  [4];
  logic [3:0]  digit_next [4];
  logic [2:0]  count_reg, count_next;
  logic        pulse_reg, pulse_next;
  logic [2:0]  back_idx;
  logic        is_digit, is_back, is_enter;

`ifdef MONTAR_PIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_reg, timer_next;
`endif

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_back  = key_valid && (key_code == KEY_BACK);
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign back_idx = count_reg - 3'd1;

  always_comb begin
    state_next = state_reg;
    digit_next = digit_reg;
    count_next = count_reg;
    pulse_next = 1'b0;
`ifdef MONTAR_PIN_TIMEOUT_EN
    timer_next = timer_reg;
`endif
    if (state_reg == SEND || !enable) begin
      // Packet already issued, or keypad disabled: drop keys and blank the buffer.
      state_next = IDLE;
      count_next = 3'd0;
      for (int i = 0; i < 4; i++) digit_next[i] = BLANK;
`ifdef MONTAR_PIN_TIMEOUT_EN
      timer_next = '0;
`endif
    end else if (is_enter) begin
      state_next = SEND;
`ifdef MONTAR_PIN_TIMEOUT_EN
      timer_next = '0;
`endif
    end else if (is_digit) begin
      state_next = COLLECT;
      if (count_reg < 3'd4) begin
        digit_next[count_reg[1:0]] = key_code;
        count_next = count_reg + 3'd1;
      end else begin
        for (int i = 0; i < 3; i++) digit_next[i] = digit_reg[i+1];
        digit_next[3] = key_code;
      end
`ifdef MONTAR_PIN_TIMEOUT_EN
      timer_next = '0;
`endif
    end else if (is_back && count_reg != 3'd0) begin
      digit_next[back_idx[1:0]] = BLANK;
      count_next = back_idx;
      if (back_idx == 3'd0) state_next = IDLE;
`ifdef MONTAR_PIN_TIMEOUT_EN
      timer_next = '0;
`endif
    end
`ifdef MONTAR_PIN_TIMEOUT_EN
    else if (state_reg == COLLECT) begin
      if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
        state_next = IDLE;
        count_next = 3'd0;
        for (int i = 0; i < 4; i++) digit_next[i] = BLANK;
        timer_next = '0;
        pulse_next = 1'b1;
      end else begin
        timer_next = timer_reg + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= 3'd0;
      pulse_reg <= 1'b0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= BLANK;
`ifdef MONTAR_PIN_TIMEOUT_EN
      timer_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      pulse_reg <= pulse_next;
      for (int i = 0; i < 4; i++) digit_reg[i] <= digit_next[i];
`ifdef MONTAR_PIN_TIMEOUT_EN
      timer_reg <= timer_next;
`endif
    end
  end

  // digit1 (oldest) occupies the nibble just below status.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pack
      assign pin_out[15-4*gi -: 4] = digit_reg[gi];
    end
  endgenerate

  assign pin_out[16]   = (state_reg == SEND);
  assign digit_count   = count_reg;
  assign timeout_pulse = pulse_reg;

endmodule

// File: tb/tb_montar_pin.sv
// Randomized and directed bench for montar_pin against a queue-based PIN model.
module tb_montar_pin;

  localparam int         TO    = 20;
  localparam logic [3:0] ENTER = 4'hF;
  localparam logic [3:0] BACK  = 4'hB;
`ifdef MONTAR_PIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [16:0] pin_out;
  logic [2:0]  digit_count;
  logic        timeout_pulse;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: the buffer is just a queue of digits, oldest first.
  logic [3:0] m_q [$];
  bit         m_send  = 1'b0;
  bit         m_pulse = 1'b0;
  int         m_timer = 0;

  montar_pin #(.TIMEOUT_CYCLES(TO), .KEY_ENTER(ENTER), .KEY_BACK(BACK)) dut (
    .clk(clk), .rst(rst), .enable(enable), .key_valid(key_valid), .key_code(key_code),
    .pin_out(pin_out), .digit_count(digit_count), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit kv, input logic [3:0] kc);
    m_pulse = 1'b0;
    if (r || m_send || !en) begin
      m_q.delete();
      m_send  = 1'b0;
      m_timer = 0;
    end else if (kv && kc == ENTER) begin
      m_send  = 1'b1;
      m_timer = 0;
    end else if (kv && kc <= 4'd9) begin
      if (m_q.size() == 4) void'(m_q.pop_front());
      m_q.push_back(kc);
      m_timer = 0;
    end else if (kv && kc == BACK && m_q.size() > 0) begin
      void'(m_q.pop_back());
      m_timer = 0;
    end else if (TO_EN && m_q.size() > 0) begin
      if (m_timer == TO - 1) begin
        m_q.delete();
        m_timer = 0;
        m_pulse = 1'b1;
      end else begin
        m_timer++;
      end
    end
  endtask

  function automatic logic [16:0] exp_pin();
    logic [16:0] v;
    v[16] = m_send;
    for (int i = 0; i < 4; i++)
      v[15-4*i -: 4] = (i < m_q.size()) ? m_q[i] : 4'hA;
    return v;
  endfunction

  task automatic tick(input bit r, input bit en, input bit kv, input logic [3:0] kc);
    rst = r; enable = en; key_valid = kv; key_code = kc;
    @(posedge clk);
    model_step(r, en, kv, kc);
    #1;
    chk("pin_out", 32'(pin_out), 32'(exp_pin()));
    chk("digit_count", 32'(digit_count), 32'(m_q.size()));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    if (pin_out[16]) $display("packet digits %h", pin_out[15:0]);
    key_valid = 1'b0;
  endtask

  task automatic key(input logic [3:0] k);
    tick(1'b0, 1'b1, 1'b1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, 4'h0);
  endtask

  initial begin
    tick(1'b1, 1'b1, 1'b0, 4'h0);
    tick(1'b1, 1'b1, 1'b0, 4'h0);
    chk("reset_pin", 32'(pin_out), 32'h0AAAA);
    chk("reset_count", 32'(digit_count), 32'd0);

    // 1..4 then ENTER
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    key(ENTER);
    chk("pkt_1234", 32'(pin_out), 32'h11234);
    idle(1);
    chk("after_send", 32'(pin_out), 32'h0AAAA);
    chk("after_send_cnt", 32'(digit_count), 32'd0);

    // Five digits shift out the oldest
    key(4'd7); key(4'd8); key(4'd9); key(4'd0); key(4'd5);
    key(ENTER);
    chk("pkt_shift", 32'(pin_out), 32'h18905);
    idle(1);

    // Backspace to empty then a partial packet
    key(4'd3); key(4'd6);
    key(BACK); chk("back_cnt1", 32'(digit_count), 32'd1);
    key(BACK); chk("back_cnt0", 32'(digit_count), 32'd0);
    key(BACK); chk("back_at0", 32'(digit_count), 32'd0);
    key(4'd4);
    key(ENTER);
    chk("pkt_partial", 32'(pin_out), 32'h14AAA);
    idle(1);
    key(ENTER);
    chk("pkt_blank", 32'(pin_out), 32'h1AAAA);
    idle(1);

    // Inactivity: expiry edge, then key landing on the expiry edge
    key(4'd5);
    idle(TO);
    chk("to_pulse", 32'(timeout_pulse), 32'(TO_EN));
    chk("to_count", 32'(digit_count), TO_EN ? 32'd0 : 32'd1);
    idle(1);
    key(BACK);
    key(4'd5);
    idle(TO - 1);
    key(4'd6);
    chk("to_race_cnt", 32'(digit_count), 32'd2);
    chk("to_race_pulse", 32'(timeout_pulse), 32'd0);
    idle(100);
    chk("long_idle_cnt", 32'(digit_count), TO_EN ? 32'd0 : 32'd2);
    tick(1'b0, 1'b0, 1'b0, 4'h0);

    // enable low clears and drops keys
    key(4'd1); key(4'd2);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    chk("en_clear", 32'(pin_out), 32'h0AAAA);
    tick(1'b0, 1'b0, 1'b1, 4'd3);
    chk("en_drop", 32'(digit_count), 32'd0);

    // Key in SEND cycle is dropped
    key(ENTER);
    key(4'd9);
    chk("send_drop", 32'(digit_count), 32'd0);

    // Reset during SEND
    key(4'd1); key(4'd2); key(4'd3);
    key(ENTER);
    tick(1'b1, 1'b1, 1'b0, 4'h0);
    chk("rst_send", 32'(pin_out), 32'h0AAAA);
    tick(1'b0, 1'b1, 1'b0, 4'h0);
    chk("rst_send_after", 32'(pin_out[16]), 32'd0);

    // Randomized traffic; strobes never on consecutive cycles
    begin
      bit last_kv = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        bit r, en, kv;
        logic [3:0] kc;
        r  = ($urandom_range(0, 99) == 0);
        en = ($urandom_range(0, 19) != 0);
        kv = !last_kv && ($urandom_range(0, 5) == 0);
        kc = 4'($urandom_range(0, 15));
        if (kc == ENTER && $urandom_range(0, 1) == 0) kc = 4'($urandom_range(0, 9));
        last_kv = kv;
        tick(r, en, kv, kc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/montar_pin.md
Name: montar_pin

Overview:
Keypad-side producer of pinPac_t packets for the password checker. Collects decoded key codes into a 4-digit PIN buffer, supports backspace and an inactivity timeout, and on ENTER issues the packet with status high for exactly one cycle. It sits between the keypad decoder and verificar_senha's pin_in port.

Parameters:
TIMEOUT_CYCLES, 250_000_000, inactivity limit in clk cycles (5 s at 50 MHz); counter width is $clog2(TIMEOUT_CYCLES+1)
KEY_ENTER, 4'hF, key code that submits the PIN
KEY_BACK, 4'hB, key code that deletes the newest digit

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  1 = accept keys; 0 = keys dropped and buffer cleared
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  4  0x0-0x9 digit, KEY_BACK, KEY_ENTER; 0xA, 0xC-0xE ignored
pin_out  output  pinPac_t  {status, digit1..digit4}, 4 bits per digit; digit1 = oldest kept digit
digit_count  output  3  digits currently held, 0..4, for display
timeout_pulse  output  1  one-cycle pulse when the buffer is discarded by timeout

Behaviour:
- Blank digit value is 4'hA. Reset: all four buffer digits 4'hA, pin_out.status 0, digit_count 0, timeout_pulse 0, timer 0, state IDLE.
- pin_out.digit1..4 are driven from registers at all times. Status is the only qualifier.
- States:
  - IDLE: buffer blank, count 0.
  - COLLECT: 1..4 digits held.
  - SEND: pin_out.status = 1 for this single cycle.
- Digit key (0-9):
  - Count < 4: digit written to position count+1; count++.
  - Count = 4: shift, digit1<=digit2, digit2<=digit3, digit3<=digit4, digit4<=new; count stays 4.
  - Goes to or stays in COLLECT.
- KEY_BACK:
  - Count > 0: position count set to 4'hA; count--. Count reaching 0 returns to IDLE.
  - Count = 0: no effect.
  - Digits lost by shifting are not restored.
- KEY_ENTER, from IDLE or COLLECT: next cycle is SEND with the current buffer. An all-blank buffer or a partial buffer is still sent; the checker flags it as a failure.
- SEND lasts exactly 1 cycle. On the next edge: status 0, buffer blank, count 0, state IDLE.
  - Key strobes arriving in the SEND cycle are dropped.
  - Net latency is ENTER strobe at edge N, status high for cycle N+1 only.
- Ignored codes (0xA, 0xC-0xE) have no effect and do not restart the timer.
- enable = 0: key strobes are dropped. If the buffer is non-empty, it is cleared on that edge and state goes to IDLE.
  - No timeout_pulse is generated.
  - A SEND already in progress completes normally.
- Timer:
  - Cleared on every accepted digit or backspace. Increments only in COLLECT.
  - Reaching TIMEOUT_CYCLES-1: buffer cleared, IDLE, timeout_pulse for 1 cycle.
  - A key accepted on the same edge as expiry wins: the key is applied and the timer clears.
- Reset asserted mid-collection or during SEND: everything returns to reset values on that edge and no packet is emitted.
- Only one key is processed per cycle; key_valid is trusted to be single-cycle.

Optional Feature:
MONTAR_PIN_TIMEOUT_EN
- Defined: inactivity timer and timeout_pulse behave as above.
- Undefined: no timer logic; timeout_pulse tied 0; buffer is held indefinitely until ENTER, backspace-to-empty, enable low, or rst.

Test Plan:
1. Keys 1,2,3,4,ENTER -> status high exactly 1 cycle with digit1..4 = 1,2,3,4; next cycle status 0, digits all 4'hA, digit_count 0.
2. Keys 7,8,9,0,5,ENTER -> shift; packet digits 8,9,0,5, status 1 cycle.
3. Keys 3,6,BACK,BACK,BACK,4,ENTER -> counts 1,2,1,0 (IDLE), 1; packet digits 4,A,A,A. ENTER alone from reset -> packet A,A,A,A.
4. Timeout (TIMEOUT_CYCLES=20 in bench, macro defined): key 5, idle 20 cycles -> timeout_pulse 1 cycle, count 0, no status; repeat with key 6 exactly at expiry -> no pulse, count 2. Macro undefined: idle 100 cycles -> buffer kept, pulse never 1.
5. Keys 1,2 then enable low 1 cycle -> buffer blank, count 0; key 3 with enable low -> ignored. ENTER followed immediately by key 9 in the SEND cycle -> 9 dropped, count 0.
6. Keys 1,2,3,ENTER with rst asserted on the SEND cycle -> status never observed high after reset edge; all outputs at reset values.
